serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor computing diff = A − B one bit per clock, LSB first, with a borrow flip-flop carried between bit slices. It is the subtract-direction counterpart to the combinational ripple adder in the arithmetic library. It trades N cycles of latency for a single full-subtractor slice. Operands enter and results leave through valid/ready handshakes, so it drops into sequential datapaths and small ALU sequencers.

---
 rtl/serial_subtractor.sv | 139 +++++++++++++
 tb/tb_serial_subtractor.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial N-bit subtractor: diff = A - B, one bit per clock, LSB first,
//   using a single full-subtractor slice and a borrow flip-flop.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair A/B valid
//   in_ready   block can accept an operand pair (high only in IDLE)
//   A, B       minuend / subtrahend, N bits
//   out_valid  result valid (high only in DONE)
//   out_ready  consumer accepts the result
//   diff       A - B modulo 2^N
//   bout       final borrow, 1 when A < B unsigned
//   ovf        signed overflow flag
//
// Configuration
//   SERIAL_SUBTRACTOR_OVF_EN  when defined, ovf reports two's-complement
//                             overflow; otherwise ovf is tied to 0.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready = 1
// SHIFT | one bit slice per cycle, N cycles
// DONE  | result held, out_valid = 1 until out_ready

module serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic          br;
  logic [CW-1:0] cnt;
  logic          d_bit;
  logic          br_nxt;
  logic          accept;
  logic          last_slice;

  // Full-subtractor slice on the operand LSBs.
  assign d_bit  = a_sr[0] ^ b_sr[0] ^ br;
  assign br_nxt = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & br) | (b_sr[0] & br);

  assign accept     = (state == IDLE) && in_valid;
  assign last_slice = (state == SHIFT) && (cnt == LAST);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else if (accept) begin
      a_sr <= A;
      b_sr <= B;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      // Result bits enter at the MSB so that after N slices bit 0 sits at diff[0].
      diff <= {d_bit, diff[N-1:1]};
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      br   <= br_nxt;
      cnt  <= cnt + CW'(1);
      if (last_slice) bout <= br_nxt;
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic sign_a;
  logic sign_b;

  // The last slice's d_bit is the result sign bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      sign_a <= A[N-1];
      sign_b <= B[N-1];
    end else if (last_slice) begin
      ovf <= (sign_a ^ sign_b) & (d_bit ^ sign_a);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor with N = 4. Expected results
//   come from an arithmetic model and are queued when operands are accepted.

module tb_serial_subtractor;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  logic [N+1:0] sb[$];

  serial_subtractor #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ovf, bout, diff}
  function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] d;
    logic         bo;
    logic         ov;
    d  = a - b;
    bo = (a < b);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ov = (a[N-1] != b[N-1]) && (d[N-1] != a[N-1]);
`else
    ov = 1'b0;
`endif
    return {ov, bo, d};
  endfunction

  // Drives one pair with out_ready high; returns edges from accept to out_valid.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       output int lat, output logic [N+1:0] act, output bit to);
    @(negedge clk);
    A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    to  = !out_valid;
    act = {ovf, bout, diff};
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if ({out_valid, ovf, bout, diff} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=0", {out_valid, ovf, bout, diff});
    end
    // Operands offered during reset must not be captured.
    in_valid = 1'b1; A = 4'd5; B = 4'd1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_no_capture got_ov=%b got_ir=%b exp=0/1", out_valid, in_ready);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat; logic [N+1:0] act; logic [N+1:0] exp; bit to;
    do_op(4'd9, 4'd3, lat, act, to);
    exp = sb.pop_front();
    checks++;
    if (to || lat != 5) begin failures++; $display("FAIL basic_latency got=%0d exp=5", lat); end
    checks++;
    if (act !== exp) begin failures++; $display("FAIL basic_result got=%h exp=%h", act, exp); end
    checks++;
    if (act[N-1:0] !== 4'd6 || act[N] !== 1'b0) begin
      failures++; $display("FAIL basic_diff got=%0d/%b exp=6/0", act[N-1:0], act[N]);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL basic_after_xfer got_ir=%b got_ov=%b exp=1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_borrow;
    int lat; logic [N+1:0] act; logic [N+1:0] exp; bit to;
    do_op(4'd3, 4'd9, lat, act, to);
    exp = sb.pop_front();
    checks++;
    if (to || act !== exp) begin failures++; $display("FAIL borrow_result got=%h exp=%h", act, exp); end
    checks++;
    if (act[N-1:0] !== 4'd10 || act[N] !== 1'b1) begin
      failures++; $display("FAIL borrow_diff got=%0d/%b exp=10/1", act[N-1:0], act[N]);
    end
  endtask

  task automatic test_edges;
    logic [N-1:0] ea[3] = '{4'd0, 4'd15, 4'd0};
    logic [N-1:0] eb[3] = '{4'd0, 4'd15, 4'd1};
    int lat; logic [N+1:0] act; logic [N+1:0] exp; bit to;
    for (int i = 0; i < 3; i++) begin
      do_op(ea[i], eb[i], lat, act, to);
      exp = sb.pop_front();
      checks++;
      if (to || lat != 5 || act !== exp) begin
        failures++; $display("FAIL edge_%0d got=%h lat=%0d exp=%h lat=5", i, act, lat, exp);
      end
    end
  endtask

  task automatic test_backpressure;
    int n; logic [N+1:0] hold; logic [N+1:0] exp; int lat;
    @(negedge clk);
    A = 4'd5; B = 4'd2; in_valid = 1'b1; out_ready = 1'b0;
    sb.push_back(model(4'd5, 4'd2));
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    checks++;
    if (!out_valid) begin failures++; $display("FAIL bp_timeout got=%b exp=1", out_valid); end
    hold = {ovf, bout, diff};
    A = 4'd12; B = 4'd7;
    sb.push_back(model(4'd12, 4'd7));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({ovf, bout, diff} !== hold || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold_%0d got=%h ir=%b ov=%b exp=%h ir=0 ov=1", i, {ovf, bout, diff}, in_ready, out_valid, hold);
      end
    end
    exp = sb.pop_front();
    checks++;
    if (hold !== exp) begin failures++; $display("FAIL bp_result got=%h exp=%h", hold, exp); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_single_xfer got_ov=%b got_ir=%b exp=0/1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    exp = sb.pop_front();
    checks++;
    if (lat != 5 || {ovf, bout, diff} !== exp) begin
      failures++; $display("FAIL bp_next got=%h lat=%0d exp=%h lat=5", {ovf, bout, diff}, lat, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_shift;
    int bad; int lat; logic [N+1:0] act; logic [N+1:0] exp; bit to;
    @(negedge clk);
    A = 4'd6; B = 4'd2; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid_immediate got_ir=%b got_ov=%b exp=1/0", in_ready, out_valid);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
      if (i == 2) rst_n = 1'b1;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rst_mid_no_result got=%0d exp=0", bad); end
    do_op(4'd8, 4'd1, lat, act, to);
    exp = sb.pop_front();
    checks++;
    if (to || lat != 5 || act !== exp) begin
      failures++; $display("FAIL rst_mid_next got=%h lat=%0d exp=%h lat=5", act, lat, exp);
    end
  endtask

  task automatic test_streaming;
    logic [N-1:0] sa[4] = '{4'd7, 4'd2, 4'd10, 4'd4};
    logic [N-1:0] sbv[4] = '{4'd2, 4'd7, 4'd10, 4'd12};
    int acc_t[4];
    int idx; int nres; int cyc; logic prev_ready; logic [N+1:0] exp;
    @(negedge clk);
    A = sa[0]; B = sbv[0]; in_valid = 1'b1; out_ready = 1'b1;
    idx = 0; nres = 0; cyc = 0;
    prev_ready = in_ready;
    while (nres < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (prev_ready && in_valid) begin
        acc_t[idx] = cyc;
        sb.push_back(model(A, B));
        idx++;
        if (idx < 4) begin A = sa[idx]; B = sbv[idx]; end
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        exp = sb.pop_front();
        checks++;
        if ({ovf, bout, diff} !== exp) begin
          failures++; $display("FAIL stream_result_%0d got=%h exp=%h", nres, {ovf, bout, diff}, exp);
        end
        nres++;
      end
      prev_ready = in_ready;
    end
    checks++;
    if (nres != 4 || idx != 4) begin
      failures++; $display("FAIL stream_count got=%0d/%0d exp=4/4", nres, idx);
    end
    for (int i = 1; i < 4; i++) begin
      if (i < idx) begin
        checks++;
        if (acc_t[i] - acc_t[i-1] != 6) begin
          failures++; $display("FAIL stream_spacing_%0d got=%0d exp=6", i, acc_t[i] - acc_t[i-1]);
        end
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_edges();
    test_backpressure();
    test_reset_mid_shift();
    test_streaming();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
